// File: rtl/arr_stream_ser_pkg.sv
// Shared types and defaults for the array-to-stream serializer.
// Optional sum beat is enabled by defining ARR_STREAM_SER_SUM_EN.
package arr_stream_ser_pkg;

  localparam int unsigned DW_DEF   = 11;
  localparam int unsigned NROW_DEF = 2;
  localparam int unsigned NCOL_DEF = 4;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic int unsigned flat_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned ncol = NCOL_DEF);
    return r * ncol + c;
  endfunction

endpackage

// File: rtl/arr_stream_ser_cnt.sv
// Beat counter: counts 0..Limit-1 on enable, wraps after the last beat, registered last flag.
// Assumes Limit >= 2.
module arr_stream_ser_cnt #(
  parameter int unsigned Limit = 8,
  parameter int unsigned Width = $clog2(Limit)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q;
  logic             last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (en_i) begin
      if (last_q) begin
        cnt_q  <= '0;
        last_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + Width'(1);
        // Flag is set when the count about to be loaded is the final one.
        last_q <= (cnt_q == Width'(Limit - 2));
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = last_q;

endmodule

// File: rtl/arr_stream_ser.sv
// Captures a NROW x NCOL word array and replays it row-major as a valid/ready stream.
// Define ARR_STREAM_SER_SUM_EN to append a modular-sum beat after the last element.
module arr_stream_ser
  import arr_stream_ser_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned NROW = NROW_DEF,
  parameter int unsigned NCOL = NCOL_DEF,
  localparam int unsigned NE  = NROW * NCOL,
`ifdef ARR_STREAM_SER_SUM_EN
  localparam int unsigned NBEAT = NE + 1,
`else
  localparam int unsigned NBEAT = NE,
`endif
  localparam int unsigned IW = $clog2(NBEAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data [NROW][NCOL],
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [IW-1:0] o_idx,
  output logic          o_last
);

  localparam int unsigned EW = $clog2(NE);

  state_t        state_q, state_d;
  logic          load;
  logic          adv;
  logic [IW-1:0] cnt;
  logic          cnt_last;
  logic [DW-1:0] buf_q [NE];

  always_comb begin
    state_d = state_q;
    i_ready = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        adv = o_ready;
        // Accept the next array only as the final beat leaves: no bubble between arrays.
        if (o_ready && cnt_last) begin
          i_ready = 1'b1;
          if (i_valid) load = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NE; k++) buf_q[k] <= '0;
    end else if (load) begin
      for (int r = 0; r < NROW; r++) begin
        for (int c = 0; c < NCOL; c++) buf_q[flat_idx(r, c, NCOL)] <= i_data[r][c];
      end
    end
  end

  arr_stream_ser_cnt #(
    .Limit (NBEAT),
    .Width (IW)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (load),
    .en_i   (adv),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

`ifdef ARR_STREAM_SER_SUM_EN
  logic [DW-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = '0;
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) sum_d = sum_d + i_data[r][c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sum_q <= '0;
    else if (load) sum_q <= sum_d;
  end
`endif

  logic [EW-1:0] eidx;
  assign eidx = cnt[EW-1:0];

  always_comb begin
    o_data = '0;
    if (state_q == SEND) begin
`ifdef ARR_STREAM_SER_SUM_EN
      if (cnt == IW'(NE)) o_data = sum_q;
      else                o_data = buf_q[eidx];
`else
      o_data = buf_q[eidx];
`endif
    end
  end

  assign o_valid = (state_q == SEND);
  assign o_idx   = cnt;
  assign o_last  = cnt_last;

endmodule

// File: doc/arr_stream_ser.md
Name: arr_stream_ser

Overview:
Downstream stage for the array-producing DUT. It captures one whole NROW x NCOL array of DW-bit words (the 2x4 x 11-bit output array) with a valid/ready handshake, then emits the words one per beat, row-major, on a valid/ready stream with last and index tags. It is the bridge from the parallel array output to the serial stream monitors and drivers in the bench.

Parameters:
DW, 11, word width in bits
NROW, 2, array rows (outer index)
NCOL, 4, array columns (inner index)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
i_valid  input  1  input array valid
i_ready  output  1  block can accept an array this cycle
i_data  input  DW x [NROW][NCOL] unpacked  input array; element [r][c]
o_valid  output  1  output word valid
o_ready  input  1  downstream accepts word
o_data  output  DW  current word
o_idx  output  $clog2(NROW*NCOL)  flat index r*NCOL+c of current word
o_last  output  1  final beat of the array

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, o_valid=0, o_data=0, o_idx=0, o_last=0, i_ready=1, buffer contents cleared to 0.
- States: IDLE, SEND.
- IDLE: i_ready=1, o_valid=0. When i_valid=1, copy the whole i_data into the buffer, set idx=0, and go to SEND on the next edge.
- SEND: o_valid=1, o_data=buf[idx/NCOL][idx%NCOL], o_idx=idx. o_last=1 when idx==NROW*NCOL-1.
- A beat transfers when o_valid & o_ready. On transfer: idx+1. On the last beat, idx wraps to 0.
- Holding rule: while o_valid=1 and o_ready=0, o_data, o_idx and o_last stay stable.
- i_ready in SEND is 1 only in the cycle the last beat transfers. In that cycle, i_valid=1 reloads the buffer, idx=0, and the state stays SEND. This gives zero bubble between arrays. If i_valid=0 in that cycle, the next state is IDLE.
- The input is captured only on i_valid & i_ready. Changes to i_data at any other time are ignored.
- Latency: input handshake to first o_valid is 1 cycle. A full array takes NROW*NCOL beats at o_ready=1.
- o_* are registered, except o_data, which is a mux off registered buf/idx.
- Reset asserted mid-array: the partial array is discarded, and after release the block returns to IDLE.

Optional Feature:
- Macro ARR_STREAM_SER_SUM_EN.
- Defined: after the last element, one extra beat is sent.
  - o_data = sum of all NROW*NCOL elements mod 2^DW.
  - o_idx = NROW*NCOL, so o_idx width becomes $clog2(NROW*NCOL+1).
  - o_last moves to this beat, and the element beat NROW*NCOL-1 has o_last=0.
  - The sum is accumulated at capture time (combinational adder tree over i_data, registered alongside the buffer).
  - The i_ready/back-to-back rule applies to the sum beat.
- Undefined: no extra beat, no adder logic.

Decomposition:
- Package arr_stream_ser_pkg:
  - default DW/NROW/NCOL localparams
  - typedef enum logic {IDLE, SEND} state_t
  - function flat_idx(r,c) returning r*NCOL+c
- One sub-module: arr_stream_ser_cnt, a beat counter with enable, wrap limit and last flag. It is reused by the bench-side deserializer.

Test Plan:
- Reset release, i_valid=0 → i_ready=1, o_valid=0, o_idx=0 for 10 cycles.
- Load c[r][c]=r*4+c+1 (1..8), o_ready=1 → o_data 1,2,…,8 on 8 consecutive cycles, o_idx 0..7, o_last only with 8; i_ready=0 during beats 1..7.
- Same array, o_ready toggling 1,0,1,0 → each word held stable while stalled; order and values unchanged; 15 cycles total.
- Two arrays back-to-back (values 1..8 then 11'h7FF in all words), i_valid held → no bubble; beat 9 = 11'h7FF with o_idx=0.
- Pull rst=0 during beat 3 of an array → outputs go to reset values immediately; a new array 1..8 after release is sent from o_idx=0.
- With ARR_STREAM_SER_SUM_EN: array 1..8 → 9th beat o_data=36, o_idx=8, o_last=1. All words 11'h7FF → sum beat 11'h7F8.
